// File: rtl/cpu_fetch.sv
// ============================================================================
// Module      : cpu_fetch
// Description : mox125 instruction fetch and alignment unit. Fetches words,
//               queues big-endian halfwords and issues one complete moxie
//               instruction per cycle. Define CPU_FETCH_STATS_EN to add the
//               bubble_count_o issue-bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_1000,
    parameter int          QUEUE_DEPTH  = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_stb_o,
    output logic [31:0] imem_address_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic [15:0] opcode_o,
    output logic [31:0] operand_o,
    output logic        valid_o,
    output logic [31:0] PC_o
`ifdef CPU_FETCH_STATS_EN
    ,
    output logic [31:0] bubble_count_o
`endif
);

    localparam int                 c_PTR_W      = $clog2(QUEUE_DEPTH);
    localparam int                 c_CNT_W      = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_PUSH_LIMIT = c_CNT_W'(QUEUE_DEPTH - 2);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE    = c_PTR_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_TWO    = c_PTR_W'(2);

    logic [15:0]        r_q [QUEUE_DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [31:0]        r_head_pc;
    logic               r_discard;

    logic               r_stb;
    logic [31:2]        r_addr;
    logic               r_drop;
    logic [31:2]        r_redirect;

    logic               r_valid;
    logic [15:0]        r_opcode;
    logic [31:0]        r_operand;
    logic [31:0]        r_pc;

    logic [15:0]        w_head;
    logic [15:0]        w_hw1;
    logic [15:0]        w_hw2;
    logic [1:0]         w_len;
    logic               w_push;
    logic               w_issue;
    logic               w_raise;
    logic [c_CNT_W-1:0] w_push_n;
    logic [c_CNT_W-1:0] w_pop_n;
    logic [c_CNT_W-1:0] w_count_next;
    logic [31:0]        w_issue_operand;
    logic               w_unused;

    function automatic logic [1:0] f_len(input logic [15:0] h);
        logic [1:0] len;
        len = 2'd1;
        if (!h[15]) begin
            case (h[15:8])
                8'h01, 8'h03, 8'h08, 8'h09, 8'h1a, 8'h1b,
                8'h1d, 8'h1f, 8'h20, 8'h22, 8'h24: len = 2'd3;
                8'h0c, 8'h0d, 8'h36, 8'h37, 8'h38, 8'h39: len = 2'd2;
                default: len = 2'd1;
            endcase
        end
        return len;
    endfunction

    assign w_unused = branch_target_i[0];

    always_comb begin
        w_head  = r_q[r_rd_ptr];
        w_hw1   = r_q[r_rd_ptr + c_PTR_ONE];
        w_hw2   = r_q[r_rd_ptr + c_PTR_TWO];
        w_len   = f_len(w_head);

        // A dropped (post-redirect) or same-cycle-redirect ack never reaches the queue.
        w_push  = r_stb && imem_ack_i && !r_drop && !branch_flag_i;
        w_issue = !stall_i && !branch_flag_i &&
                  (r_count >= {{(c_CNT_W-2){1'b0}}, w_len});

        w_push_n = '0;
        if (w_push) begin
            w_push_n = r_discard ? c_CNT_W'(1) : c_CNT_W'(2);
        end
        w_pop_n = w_issue ? {{(c_CNT_W-2){1'b0}}, w_len} : '0;

        w_count_next = branch_flag_i ? '0 : (r_count + w_push_n - w_pop_n);
        // Request only when two pushes are guaranteed to fit on arrival.
        w_raise = !r_stb && (w_count_next <= c_PUSH_LIMIT);

        case (w_len)
            2'd3:    w_issue_operand = {w_hw1, w_hw2};
            2'd2:    w_issue_operand = {w_hw1, 16'h0000};
            default: w_issue_operand = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            if (r_discard) begin
                r_q[r_wr_ptr] <= imem_data_i[15:0];
            end else begin
                r_q[r_wr_ptr]             <= imem_data_i[31:16];
                r_q[r_wr_ptr + c_PTR_ONE] <= imem_data_i[15:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_head_pc <= RESET_VECTOR;
            r_discard <= 1'b0;
        end else begin
            r_count <= w_count_next;
            if (branch_flag_i) begin
                r_rd_ptr  <= '0;
                r_wr_ptr  <= '0;
                r_head_pc <= {branch_target_i[31:1], 1'b0};
                r_discard <= branch_target_i[1];
            end else begin
                if (w_push) begin
                    r_wr_ptr  <= r_wr_ptr + w_push_n[c_PTR_W-1:0];
                    r_discard <= 1'b0;
                end
                if (w_issue) begin
                    r_rd_ptr  <= r_rd_ptr + w_pop_n[c_PTR_W-1:0];
                    r_head_pc <= r_head_pc + {29'd0, w_len, 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stb      <= 1'b0;
            r_addr     <= RESET_VECTOR[31:2];
            r_drop     <= 1'b0;
            r_redirect <= RESET_VECTOR[31:2];
        end else if (r_stb) begin
            if (imem_ack_i) begin
                r_stb  <= 1'b0;
                r_drop <= 1'b0;
                if (branch_flag_i) begin
                    r_addr <= branch_target_i[31:2];
                end else if (r_drop) begin
                    r_addr <= r_redirect;
                end else begin
                    r_addr <= r_addr + 30'd1;
                end
            end else if (branch_flag_i) begin
                // Bus cycle must finish at the old address; remember where to go next.
                r_drop     <= 1'b1;
                r_redirect <= branch_target_i[31:2];
            end
        end else begin
            if (branch_flag_i) begin
                r_addr <= branch_target_i[31:2];
            end
            if (w_raise) begin
                r_stb <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid   <= 1'b0;
            r_opcode  <= 16'h0000;
            r_operand <= 32'h0000_0000;
            r_pc      <= RESET_VECTOR;
        end else if (branch_flag_i) begin
            r_valid <= 1'b0;
        end else if (!stall_i) begin
            r_valid <= w_issue;
            if (w_issue) begin
                r_opcode  <= w_head;
                r_operand <= w_issue_operand;
                r_pc      <= r_head_pc;
            end
        end
    end

`ifdef CPU_FETCH_STATS_EN
    logic [31:0] r_bubble_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bubble_count <= 32'd0;
        end else if (!stall_i && !branch_flag_i && !w_issue) begin
            r_bubble_count <= r_bubble_count + 32'd1;
        end
    end

    assign bubble_count_o = r_bubble_count;
`endif

    assign imem_stb_o     = r_stb;
    assign imem_address_o = {r_addr, 2'b00};
    assign opcode_o       = r_opcode;
    assign operand_o      = r_operand;
    assign valid_o        = r_valid;
    assign PC_o           = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_cpu_fetch.sv
// ============================================================================
// Module      : tb_cpu_fetch
// Description : Self-checking bench for cpu_fetch with a word memory model
//               and an instruction-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_fetch;

    localparam logic [31:0] RV = 32'h0000_1000;

    logic        clk;
    logic        rst_i;
    logic        imem_stb_o;
    logic [31:0] imem_address_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [15:0] opcode_o;
    logic [31:0] operand_o;
    logic        valid_o;
    logic [31:0] PC_o;
`ifdef CPU_FETCH_STATS_EN
    logic [31:0] bubble_count_o;
`endif

    logic [31:0] mem [4096];
    int          n_checks   = 0;
    int          n_pass     = 0;
    int          exp_bubble = 0;
    int          ack_lat    = 1;
    bit          rand_lat   = 0;
    logic [7:0]  len3_ops [11] = '{8'h01, 8'h03, 8'h08, 8'h09, 8'h1a, 8'h1b,
                                   8'h1d, 8'h1f, 8'h20, 8'h22, 8'h24};
    logic [7:0]  len2_ops [6]  = '{8'h0c, 8'h0d, 8'h36, 8'h37, 8'h38, 8'h39};

    cpu_fetch #(.RESET_VECTOR(RV), .QUEUE_DEPTH(8)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .imem_stb_o     (imem_stb_o),
        .imem_address_o (imem_address_o),
        .imem_ack_i     (imem_ack_i),
        .imem_data_i    (imem_data_i),
        .stall_i        (stall_i),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .opcode_o       (opcode_o),
        .operand_o      (operand_o),
        .valid_o        (valid_o),
        .PC_o           (PC_o)
`ifdef CPU_FETCH_STATS_EN
        ,
        .bubble_count_o (bubble_count_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: acks the N-th cycle a request has been held.
    initial begin
        int cnt;
        int tgt;
        cnt = 0;
        tgt = 1;
        imem_ack_i  = 1'b0;
        imem_data_i = 32'h0;
        forever begin
            @(negedge clk);
            imem_ack_i = 1'b0;
            if (imem_stb_o === 1'b1 && rst_i === 1'b0) begin
                if (cnt == 0) tgt = rand_lat ? int'($urandom_range(1, 4)) : ack_lat;
                cnt++;
                if (cnt >= tgt) begin
                    imem_ack_i  = 1'b1;
                    imem_data_i = mem[imem_address_o[13:2]];
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- reference model (spec-level) ----------------
    function automatic logic [15:0] ref_hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[13:2]];
        return a[1] ? w[15:0] : w[31:16];
    endfunction

    function automatic int ref_len(input logic [15:0] h);
        if (h[15]) return 1;
        foreach (len3_ops[i]) if (h[15:8] == len3_ops[i]) return 3;
        foreach (len2_ops[i]) if (h[15:8] == len2_ops[i]) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] ref_operand(input logic [31:0] pc);
        int n;
        n = ref_len(ref_hw(pc));
        if (n == 3) return {ref_hw(pc + 2), ref_hw(pc + 4)};
        if (n == 2) return {ref_hw(pc + 2), 16'h0000};
        return 32'h0;
    endfunction

    function automatic logic [15:0] rand_hw();
        logic [7:0] lo;
        lo = 8'($urandom);
        case ($urandom_range(0, 3))
            0:       return {1'b1, 15'($urandom)};
            1:       return {len3_ops[$urandom_range(0, 10)], lo};
            2:       return {len2_ops[$urandom_range(0, 5)], lo};
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < 4096; i++) mem[i] = v;
    endtask

    task automatic tick();
        logic s, b, r;
        s = stall_i;
        b = branch_flag_i;
        r = rst_i;
        @(negedge clk);
        #1;
        if (r) exp_bubble = 0;
        else if (!s && !b && !valid_o) exp_bubble++;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        stall_i = 1'b0;
        branch_flag_i = 1'b0;
        branch_target_i = 32'h0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b1;
        stall_i = 1'b0;
        branch_flag_i = 1'b0;
        branch_target_i = 32'h0;
        tick();
        tick();
        n_checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else n_pass++;
        n_checks++; if (opcode_o !== 16'h0) $display("FAIL reset_opcode: got %h want 0000", opcode_o); else n_pass++;
        n_checks++; if (operand_o !== 32'h0) $display("FAIL reset_operand: got %h want 0", operand_o); else n_pass++;
        n_checks++; if (PC_o !== RV) $display("FAIL reset_pc: got %h want %h", PC_o, RV); else n_pass++;
        n_checks++; if (imem_stb_o !== 1'b0) $display("FAIL reset_stb: got %b want 0", imem_stb_o); else n_pass++;
        n_checks++; if (imem_address_o !== RV) $display("FAIL reset_addr: got %h want %h", imem_address_o, RV); else n_pass++;
`ifdef CPU_FETCH_STATS_EN
        n_checks++; if (bubble_count_o !== 32'h0) $display("FAIL reset_bubble: got %0d want 0", bubble_count_o); else n_pass++;
`endif
        rst_i = 1'b0;
    endtask

    task automatic test_len3_len1();
        logic [15:0] e_op  [2] = '{16'h0120, 16'h0f00};
        logic [31:0] e_opr [2] = '{32'h0000_0005, 32'h0};
        logic [31:0] e_pc  [2] = '{32'h1000, 32'h1006};
        int seen;
        fill(32'h8105_8105);
        mem[32'h1000 >> 2] = 32'h0120_0000;
        mem[32'h1004 >> 2] = 32'h0005_0f00;
        ack_lat = 1; rand_lat = 0;
        apply_reset();
        seen = 0;
        for (int c = 0; c < 40 && seen < 2; c++) begin
            tick();
            if (valid_o === 1'b1) begin
                n_checks++; if (opcode_o !== e_op[seen]) $display("FAIL basic_opcode%0d: got %h want %h", seen, opcode_o, e_op[seen]); else n_pass++;
                n_checks++; if (operand_o !== e_opr[seen]) $display("FAIL basic_operand%0d: got %h want %h", seen, operand_o, e_opr[seen]); else n_pass++;
                n_checks++; if (PC_o !== e_pc[seen]) $display("FAIL basic_pc%0d: got %h want %h", seen, PC_o, e_pc[seen]); else n_pass++;
                seen++;
            end
        end
        n_checks++; if (seen != 2) $display("FAIL basic_timeout: got %0d issues want 2", seen); else n_pass++;
    endtask

    task automatic test_len2();
        int seen;
        fill(32'h8105_8105);
        mem[32'h1000 >> 2] = 32'h0c12_00ff;
        ack_lat = 1; rand_lat = 0;
        apply_reset();
        seen = 0;
        for (int c = 0; c < 40 && seen < 2; c++) begin
            tick();
            if (valid_o === 1'b1) begin
                if (seen == 0) begin
                    n_checks++; if (opcode_o !== 16'h0c12) $display("FAIL len2_opcode: got %h want 0c12", opcode_o); else n_pass++;
                    n_checks++; if (operand_o !== 32'h00ff_0000) $display("FAIL len2_operand: got %h want 00ff0000", operand_o); else n_pass++;
                    n_checks++; if (PC_o !== 32'h1000) $display("FAIL len2_pc: got %h want 00001000", PC_o); else n_pass++;
                end else begin
                    n_checks++; if (PC_o !== 32'h1004) $display("FAIL len2_next_pc: got %h want 00001004", PC_o); else n_pass++;
                end
                seen++;
            end
        end
        n_checks++; if (seen != 2) $display("FAIL len2_timeout: got %0d issues want 2", seen); else n_pass++;
    endtask

    task automatic test_branch_pending();
        int phase;
        bit got;
        fill(32'h8105_8105);
        for (int i = 0; i < 16; i++) mem[(32'h1000 >> 2) + i] = 32'h8aaa_8bbb;
        mem[32'h2000 >> 2] = 32'h7777_8123;
        ack_lat = 3; rand_lat = 0;
        apply_reset();
        for (int c = 0; c < 10 && imem_stb_o !== 1'b1; c++) tick();
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_2002;
        tick();
        branch_flag_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL bp_valid: got %b want 0", valid_o); else n_pass++;
        phase = 0;
        got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (phase == 0) begin
                if (imem_stb_o === 1'b1) begin
                    n_checks++; if (imem_address_o !== 32'h1000) $display("FAIL bp_old_addr: got %h want 00001000", imem_address_o); else n_pass++;
                end else phase = 1;
            end else if (phase == 1 && imem_stb_o === 1'b1) begin
                n_checks++; if (imem_address_o !== 32'h2000) $display("FAIL bp_new_addr: got %h want 00002000", imem_address_o); else n_pass++;
                phase = 2;
            end
            if (valid_o === 1'b1) begin
                n_checks++; if (PC_o !== 32'h2002) $display("FAIL bp_first_pc: got %h want 00002002", PC_o); else n_pass++;
                n_checks++; if (opcode_o !== 16'h8123) $display("FAIL bp_first_op: got %h want 8123", opcode_o); else n_pass++;
                got = 1;
            end
            tick();
        end
        n_checks++; if (!got || phase != 2) $display("FAIL bp_timeout: got phase %0d issued %0d want 2 1", phase, got); else n_pass++;
    endtask

    task automatic test_stall();
        logic [15:0] s_op;
        logic [31:0] s_pc;
        int c;
        fill(32'h8105_8105);
        ack_lat = 1; rand_lat = 0;
        apply_reset();
        for (c = 0; c < 20 && valid_o !== 1'b1; c++) tick();
        tick(); tick(); tick();
        n_checks++; if (valid_o !== 1'b1) $display("FAIL stall_pre_valid: got %b want 1", valid_o); else n_pass++;
        s_op = opcode_o;
        s_pc = PC_o;
        stall_i = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if ({valid_o, opcode_o, PC_o} !== {1'b1, s_op, s_pc})
                $display("FAIL stall_hold%0d: got %b/%h/%h want 1/%h/%h", k, valid_o, opcode_o, PC_o, s_op, s_pc);
            else n_pass++;
            if (k >= 8) begin
                n_checks++; if (imem_stb_o !== 1'b0) $display("FAIL stall_full_stb%0d: got %b want 0", k, imem_stb_o); else n_pass++;
            end
        end
        stall_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if ({valid_o, opcode_o, PC_o} !== {1'b1, 16'h8105, s_pc + 32'(2 * k)})
                $display("FAIL stall_resume%0d: got %b/%h/%h want 1/8105/%h", k, valid_o, opcode_o, PC_o, s_pc + 32'(2 * k));
            else n_pass++;
        end
    endtask

    task automatic test_branch_same_ack();
        bit got;
        fill(32'h8111_8222);
        mem[32'h3000 >> 2] = 32'h8333_8444;
        ack_lat = 2; rand_lat = 0;
        apply_reset();
        for (int c = 0; c < 10 && !(imem_stb_o === 1'b1 && imem_ack_i === 1'b1); c++) tick();
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_3000;
        tick();
        branch_flag_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL ba_valid: got %b want 0", valid_o); else n_pass++;
        got = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            tick();
            if (valid_o === 1'b1) begin
                n_checks++; if (PC_o !== 32'h3000) $display("FAIL ba_pc: got %h want 00003000", PC_o); else n_pass++;
                n_checks++; if (opcode_o !== 16'h8333) $display("FAIL ba_op: got %h want 8333", opcode_o); else n_pass++;
                got = 1;
            end
        end
        n_checks++; if (!got) $display("FAIL ba_timeout: got 0 issues want 1"); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, p_target, p_addr, s_operand, s_pc, e_opr;
        logic [15:0] s_op, e_op;
        logic        p_stall, p_branch, p_stb, p_ack, s_valid;
        int          issued;
        for (int i = 0; i < 4096; i++) mem[i] = {rand_hw(), rand_hw()};
        rand_lat = 1;
        apply_reset();
        exp_pc = RV;
        issued = 0;
        {s_valid, s_op, s_operand, s_pc} = {valid_o, opcode_o, operand_o, PC_o};
        for (int c = 0; c < 800; c++) begin
            stall_i         = ($urandom_range(0, 99) < 25);
            branch_flag_i   = ($urandom_range(0, 99) < 4);
            branch_target_i = 32'h0000_1000 | 32'($urandom_range(0, 32'h0fff));
            {p_stall, p_branch, p_target} = {stall_i, branch_flag_i, branch_target_i};
            {p_stb, p_ack, p_addr} = {imem_stb_o, imem_ack_i, imem_address_o};
            tick();
            if (p_branch) begin
                n_checks++; if (valid_o !== 1'b0) $display("FAIL rnd_branch_valid c%0d: got %b want 0", c, valid_o); else n_pass++;
                exp_pc = {p_target[31:1], 1'b0};
            end else if (p_stall) begin
                n_checks++;
                if ({valid_o, opcode_o, operand_o, PC_o} !== {s_valid, s_op, s_operand, s_pc})
                    $display("FAIL rnd_stall_hold c%0d: got %b/%h/%h/%h want %b/%h/%h/%h", c, valid_o, opcode_o, operand_o, PC_o, s_valid, s_op, s_operand, s_pc);
                else n_pass++;
            end else if (valid_o === 1'b1) begin
                e_op  = ref_hw(exp_pc);
                e_opr = ref_operand(exp_pc);
                n_checks++;
                if ({opcode_o, operand_o, PC_o} !== {e_op, e_opr, exp_pc})
                    $display("FAIL rnd_issue c%0d: got %h/%h/%h want %h/%h/%h", c, opcode_o, operand_o, PC_o, e_op, e_opr, exp_pc);
                else n_pass++;
                exp_pc = exp_pc + 32'(2 * ref_len(e_op));
                issued++;
            end
            if (p_stb && !p_ack) begin
                n_checks++;
                if ({imem_stb_o, imem_address_o} !== {1'b1, p_addr})
                    $display("FAIL rnd_bus_hold c%0d: got %b/%h want 1/%h", c, imem_stb_o, imem_address_o, p_addr);
                else n_pass++;
            end
            n_checks++; if (imem_address_o[1:0] !== 2'b00) $display("FAIL rnd_addr_align c%0d: got %h want xxxxxxx0", c, imem_address_o); else n_pass++;
            {s_valid, s_op, s_operand, s_pc} = {valid_o, opcode_o, operand_o, PC_o};
        end
        stall_i = 1'b0;
        branch_flag_i = 1'b0;
        rand_lat = 0;
        n_checks++; if (issued < 50) $display("FAIL rnd_progress: got %0d issues want >= 50", issued); else n_pass++;
    endtask

`ifdef CPU_FETCH_STATS_EN
    task automatic test_bubble();
        fill(32'h8105_8105);
        ack_lat = 4; rand_lat = 0;
        apply_reset();
        for (int c = 0; c < 60; c++) begin
            stall_i = (c >= 20 && c < 26);
            tick();
        end
        stall_i = 1'b0;
        n_checks++; if (bubble_count_o !== 32'(exp_bubble)) $display("FAIL bubble_count: got %0d want %0d", bubble_count_o, exp_bubble); else n_pass++;
    endtask
`endif

    initial begin
        rst_i = 1'b1;
        stall_i = 1'b0;
        branch_flag_i = 1'b0;
        branch_target_i = 32'h0;
        fill(32'h8105_8105);
        test_reset();
        test_len3_len1();
        test_len2();
        test_branch_pending();
        test_stall();
        test_branch_same_ack();
        test_random();
`ifdef CPU_FETCH_STATS_EN
        test_bubble();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
